sw_avm_seq_bridge: RTL and testbench
====================================

Name: sw_avm_seq_bridge

Overview:
- Next-generation Avalon-MM UART bridge for the Smith-Waterman accelerator.
- Polls the RS232 core's status/RX/TX registers and receives a length-prefixed frame: ref length, read length, then 2-bit-packed bases.
- Drives an external SW core over valid/ready handshakes, then serialises the score, row and column back over TX.
- Adds runtime lengths, parametrised buffer/result widths, header validation and an inactivity timeout that discards partial frames.

Parameters:
- REF_MAX_LENGTH, 128: max ref bases; ref buffer = 2*REF_MAX_LENGTH bits; multiple of 4, ≤255.
- READ_MAX_LENGTH, 128: max read bases; same rules.
- RES_W, 64: width of each result field; multiple of 8.
- TIMEOUT_CYCLES, 50000: idle cycles mid-frame before the frame is discarded.
- LEN_W, 8: width of the length header fields.

Ports:
- avm_clk  in  1  clock
- avm_rst  in  1  synchronous active-high reset
- avm_address  out  5  RS232 register address: RX=0, TX=4, STATUS=8
- avm_read  out  1  read request
- avm_readdata  in  32  read data; STATUS bit7=RX ready, bit6=TX ready
- avm_write  out  1  write request
- avm_writedata  out  32  [7:0]=TX byte, [31:8]=0
- avm_waitrequest  in  1  slave stall
- core_in_valid  out  1  sequences/lengths valid
- core_in_ready  in  1  core accepts input
- core_ref  out  2*REF_MAX_LENGTH  packed ref bases
- core_read  out  2*READ_MAX_LENGTH  packed read bases
- core_ref_len  out  LEN_W  ref length
- core_read_len  out  LEN_W  read length
- core_out_valid  in  1  result valid
- core_out_ready  out  1  bridge accepts result
- core_score, core_row, core_column  in  RES_W each  results
- busy  out  1  high from first header byte until the last TX byte completes

Behaviour:
- Avalon transfer: a request is held until the cycle in which it is asserted with avm_waitrequest=0; that cycle completes it. Exactly one of avm_read/avm_write is high at any time.
- Reset values:
  - avm_read=1, avm_address=8, avm_write=0, avm_writedata=0.
  - core_in_valid=0, core_out_ready=0, busy=0.
  - Buffers and lengths 0; state S_POLL_RX, phase HDR0.
- S_POLL_RX: read STATUS. On completion with bit7=1 → S_GET with an RX read; else stay.
- S_GET: on completion, take byte = avm_readdata[7:0] according to phase:
  - HDR0: store ref_len, clear both buffers.
  - HDR1: store read_len. If either length is 0 or exceeds its max → error: load TX frame of one byte 0xEE, go to S_POLL_TX. Otherwise set nref=ceil(ref_len/4), nread=ceil(read_len/4).
  - REF: byte k (k=0..nref-1) goes to core_ref[2*REF_MAX_LENGTH-1-8k -: 8].
  - READ: byte k goes to core_read analogously (MSB-first); unused low bytes stay 0.
  - After the last READ byte → S_CORE_REQ; otherwise → S_POLL_RX.
- Timeout: idle counter cleared on every RX byte; increments in S_POLL_RX only when phase≠HDR0. Reaching TIMEOUT_CYCLES → phase=HDR0, busy=0, no TX.
- S_CORE_REQ: core_in_valid=1, data stable; on core_in_ready=1 → drop valid next cycle, go to S_CORE_WAIT.
- S_CORE_WAIT: core_out_ready=1; on core_out_valid=1 capture {column,row,score}, frame length = 3*RES_W/8 bytes, → S_POLL_TX.
- S_POLL_TX: read STATUS; on completion with bit6=1 → S_PUT with a TX write of the current MSB byte.
- S_PUT: on completion shift the frame left 8 bits and decrement the count. Count reaches 0 → S_POLL_RX, phase HDR0, busy=0; else → S_POLL_TX.
- TX byte order: column MSB first, then row, then score. No padding bytes.
- Reset mid-operation: returns to reset values on the next edge; a partial frame is discarded.

Optional Feature:
- Macro SW_BRIDGE_CHECKSUM_EN.
- Defined: one extra TX byte is appended after every frame, including the 0xEE error frame. It is the XOR of all preceding frame bytes.
- Undefined: the frame is exactly as above.

Test Plan:
- Header 0x80,0x80 with 32+32 payload bytes 0x1B.. → core_ref[255:248]=first ref byte, core_ref_len=128; core returns score=5,row=7,col=9 → 24 TX bytes, column bytes first, last byte 0x05.
- Header 0x05,0x03 → 2 ref + 1 read bytes accepted, core_ref[255:240] loaded, remaining bits 0; core_in_valid asserts after 5th byte.
- Header 0x00 or 0x81 (max 128) → single TX byte 0xEE, no core_in_valid; next valid frame processed normally.
- Header + 10 payload bytes, then silence TIMEOUT_CYCLES → busy falls, no TX; new full frame yields correct result.
- avm_waitrequest held high 3 cycles on each access, core_in_ready delayed 4 cycles → request signals held, no byte lost, identical result bytes.
- With SW_BRIDGE_CHECKSUM_EN, result score=1,row=0,col=0 (RES_W=64) → 25 bytes, final byte 0x01.

Source files
------------

// File: rtl/sw_avm_seq_bridge.sv
// Avalon-MM RS232 bridge for the Smith-Waterman core: receives length-prefixed base frames,
// hands them to the core and returns column/row/score. SW_BRIDGE_CHECKSUM_EN adds an XOR byte.
module sw_avm_seq_bridge #(
   parameter int unsigned REF_MAX_LENGTH  = 128,
   parameter int unsigned READ_MAX_LENGTH = 128,
   parameter int unsigned RES_W           = 64,
   parameter int unsigned TIMEOUT_CYCLES  = 50000,
   parameter int unsigned LEN_W           = 8
) (
   input  logic                         avm_clk,
   input  logic                         avm_rst,
   output logic [4:0]                   avm_address,
   output logic                         avm_read,
   input  logic [31:0]                  avm_readdata,
   output logic                         avm_write,
   output logic [31:0]                  avm_writedata,
   input  logic                         avm_waitrequest,
   output logic                         core_in_valid,
   input  logic                         core_in_ready,
   output logic [2*REF_MAX_LENGTH-1:0]  core_ref,
   output logic [2*READ_MAX_LENGTH-1:0] core_read,
   output logic [LEN_W-1:0]             core_ref_len,
   output logic [LEN_W-1:0]             core_read_len,
   input  logic                         core_out_valid,
   output logic                         core_out_ready,
   input  logic [RES_W-1:0]             core_score,
   input  logic [RES_W-1:0]             core_row,
   input  logic [RES_W-1:0]             core_column,
   output logic                         busy
);

   localparam int unsigned REF_W     = 2 * REF_MAX_LENGTH;
   localparam int unsigned READ_W    = 2 * READ_MAX_LENGTH;
   localparam int unsigned RES_BYTES = 3 * RES_W / 8;
`ifdef SW_BRIDGE_CHECKSUM_EN
   localparam int unsigned FRAME_BYTES = RES_BYTES + 1;
   localparam int unsigned ERR_BYTES   = 2;
`else
   localparam int unsigned FRAME_BYTES = RES_BYTES;
   localparam int unsigned ERR_BYTES   = 1;
`endif
   localparam int unsigned FRAME_W = 8 * FRAME_BYTES;
   localparam int unsigned CNT_W   = $clog2(FRAME_BYTES + 1);
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [FRAME_W-1:0] ERR_FRAME =
      {{ERR_BYTES{8'hEE}}, {(FRAME_W - 8 * ERR_BYTES){1'b0}}};
   localparam logic [TO_W-1:0] IDLE_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_POLL_RX   = 3'd0;
   localparam logic [2:0] S_GET       = 3'd1;
   localparam logic [2:0] S_CORE_REQ  = 3'd2;
   localparam logic [2:0] S_CORE_WAIT = 3'd3;
   localparam logic [2:0] S_POLL_TX   = 3'd4;
   localparam logic [2:0] S_PUT       = 3'd5;

   localparam logic [1:0] PH_HDR0 = 2'd0;
   localparam logic [1:0] PH_HDR1 = 2'd1;
   localparam logic [1:0] PH_REF  = 2'd2;
   localparam logic [1:0] PH_READ = 2'd3;

   localparam logic [4:0] ADDR_RX     = 5'd0;
   localparam logic [4:0] ADDR_TX     = 5'd4;
   localparam logic [4:0] ADDR_STATUS = 5'd8;

   logic [2:0]         state_q, state_d;
   logic [1:0]         phase_q, phase_d;
   logic [REF_W-1:0]   ref_buf_q, ref_buf_d;
   logic [READ_W-1:0]  read_buf_q, read_buf_d;
   logic [LEN_W-1:0]   ref_len_q, ref_len_d;
   logic [LEN_W-1:0]   read_len_q, read_len_d;
   logic [7:0]         nref_q, nref_d;
   logic [7:0]         nread_q, nread_d;
   logic [7:0]         idx_q, idx_d;
   logic [TO_W-1:0]    idle_q, idle_d;
   logic               busy_q, busy_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic                 xfer_done;
   logic [7:0]           rx_byte;
   logic [LEN_W-1:0]     hdr_len;
   logic                 len_bad;
   logic [3*RES_W-1:0]   res_word;
   logic [FRAME_W-1:0]   res_frame;
   logic                 unused_rdata;

   assign xfer_done    = (avm_read | avm_write) & ~avm_waitrequest;
   assign rx_byte      = avm_readdata[7:0];
   assign hdr_len      = LEN_W'(rx_byte);
   assign unused_rdata = ^avm_readdata[31:8];
   assign res_word     = {core_column, core_row, core_score};

   // ref length was latched at HDR0; read length is the byte arriving now
   assign len_bad = (ref_len_q == '0) || (32'(ref_len_q) > REF_MAX_LENGTH) ||
                    (hdr_len == '0) || (32'(hdr_len) > READ_MAX_LENGTH);

`ifdef SW_BRIDGE_CHECKSUM_EN
   logic [7:0] res_chk;

   always_comb begin
      res_chk = 8'h00;
      for (int i = 0; i < int'(RES_BYTES); i++) begin
         res_chk = res_chk ^ res_word[8*i +: 8];
      end
   end

   assign res_frame = {res_word, res_chk};
`else
   assign res_frame = res_word;
`endif

   // Avalon request is a pure function of state, so it is held across waitrequest by design.
   always_comb begin
      avm_read      = 1'b1;
      avm_write     = 1'b0;
      avm_address   = ADDR_STATUS;
      avm_writedata = 32'h0;
      case (state_q)
         S_GET: avm_address = ADDR_RX;
         S_PUT: begin
            avm_read      = 1'b0;
            avm_write     = 1'b1;
            avm_address   = ADDR_TX;
            avm_writedata = {24'h0, frame_q[FRAME_W-1 -: 8]};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      ref_buf_d  = ref_buf_q;
      read_buf_d = read_buf_q;
      ref_len_d  = ref_len_q;
      read_len_d = read_len_q;
      nref_d     = nref_q;
      nread_d    = nread_q;
      idx_d      = idx_q;
      idle_d     = idle_q;
      busy_d     = busy_q;
      frame_d    = frame_q;
      cnt_d      = cnt_q;

      case (state_q)
         S_POLL_RX: begin
            if (xfer_done && avm_readdata[7]) begin
               state_d = S_GET;
            end else if (phase_q != PH_HDR0) begin
               if (idle_q == IDLE_LAST) begin
                  phase_d = PH_HDR0;
                  busy_d  = 1'b0;
                  idle_d  = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end

         S_GET: begin
            if (xfer_done) begin
               idle_d  = '0;
               state_d = S_POLL_RX;
               case (phase_q)
                  PH_HDR0: begin
                     ref_len_d  = hdr_len;
                     ref_buf_d  = '0;
                     read_buf_d = '0;
                     busy_d     = 1'b1;
                     phase_d    = PH_HDR1;
                  end
                  PH_HDR1: begin
                     read_len_d = hdr_len;
                     if (len_bad) begin
                        frame_d = ERR_FRAME;
                        cnt_d   = CNT_W'(ERR_BYTES);
                        state_d = S_POLL_TX;
                     end else begin
                        nref_d  = 8'((32'(ref_len_q) + 32'd3) >> 2);
                        nread_d = 8'((32'(hdr_len) + 32'd3) >> 2);
                        idx_d   = 8'd0;
                        phase_d = PH_REF;
                     end
                  end
                  PH_REF: begin
                     ref_buf_d = ref_buf_q |
                                 (REF_W'(rx_byte) << (REF_W - 8 - 8 * 32'(idx_q)));
                     if (idx_q + 8'd1 == nref_q) begin
                        idx_d   = 8'd0;
                        phase_d = PH_READ;
                     end else begin
                        idx_d = idx_q + 8'd1;
                     end
                  end
                  default: begin
                     read_buf_d = read_buf_q |
                                  (READ_W'(rx_byte) << (READ_W - 8 - 8 * 32'(idx_q)));
                     if (idx_q + 8'd1 == nread_q) begin
                        idx_d   = 8'd0;
                        state_d = S_CORE_REQ;
                     end else begin
                        idx_d = idx_q + 8'd1;
                     end
                  end
               endcase
            end
         end

         S_CORE_REQ: begin
            if (core_in_ready) state_d = S_CORE_WAIT;
         end

         S_CORE_WAIT: begin
            if (core_out_valid) begin
               frame_d = res_frame;
               cnt_d   = CNT_W'(FRAME_BYTES);
               state_d = S_POLL_TX;
            end
         end

         S_POLL_TX: begin
            if (xfer_done && avm_readdata[6]) state_d = S_PUT;
         end

         S_PUT: begin
            if (xfer_done) begin
               frame_d = frame_q << 8;
               cnt_d   = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_POLL_RX;
                  phase_d = PH_HDR0;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_POLL_TX;
               end
            end
         end

         default: state_d = S_POLL_RX;
      endcase
   end

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         state_q    <= S_POLL_RX;
         phase_q    <= PH_HDR0;
         ref_buf_q  <= '0;
         read_buf_q <= '0;
         ref_len_q  <= '0;
         read_len_q <= '0;
         nref_q     <= '0;
         nread_q    <= '0;
         idx_q      <= '0;
         idle_q     <= '0;
         busy_q     <= 1'b0;
         frame_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         ref_buf_q  <= ref_buf_d;
         read_buf_q <= read_buf_d;
         ref_len_q  <= ref_len_d;
         read_len_q <= read_len_d;
         nref_q     <= nref_d;
         nread_q    <= nread_d;
         idx_q      <= idx_d;
         idle_q     <= idle_d;
         busy_q     <= busy_d;
         frame_q    <= frame_d;
         cnt_q      <= cnt_d;
      end
   end

   assign core_in_valid  = (state_q == S_CORE_REQ);
   assign core_out_ready = (state_q == S_CORE_WAIT);
   assign core_ref       = ref_buf_q;
   assign core_read      = read_buf_q;
   assign core_ref_len   = ref_len_q;
   assign core_read_len  = read_len_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_sw_avm_seq_bridge.sv
// Bench for sw_avm_seq_bridge: RS232 register model, SW core model and a frame-level
// reference model (expected buffers and TX bytes built from the frame rules).
`timescale 1ns/1ps
module tb_sw_avm_seq_bridge;

   localparam int unsigned REF_MAX  = 128;
   localparam int unsigned READ_MAX = 128;
   localparam int unsigned RES_W    = 64;
   localparam int unsigned TIMEOUT  = 400;
   localparam int unsigned LEN_W    = 8;
   localparam int unsigned REF_W    = 2 * REF_MAX;
   localparam int unsigned READ_W   = 2 * READ_MAX;
   localparam int          LIMIT    = 30000;
`ifdef SW_BRIDGE_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic              avm_clk = 1'b0;
   logic              avm_rst = 1'b1;
   logic [4:0]        avm_address;
   logic              avm_read;
   logic [31:0]       avm_readdata = 32'h0;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic              avm_waitrequest = 1'b1;
   logic              core_in_valid;
   logic              core_in_ready = 1'b0;
   logic [REF_W-1:0]  core_ref;
   logic [READ_W-1:0] core_read;
   logic [LEN_W-1:0]  core_ref_len;
   logic [LEN_W-1:0]  core_read_len;
   logic              core_out_valid = 1'b0;
   logic              core_out_ready;
   logic [RES_W-1:0]  core_score;
   logic [RES_W-1:0]  core_row;
   logic [RES_W-1:0]  core_column;
   logic              busy;

   logic [RES_W-1:0] res_score = '0;
   logic [RES_W-1:0] res_row   = '0;
   logic [RES_W-1:0] res_col   = '0;
   assign core_score  = res_score;
   assign core_row    = res_row;
   assign core_column = res_col;

   sw_avm_seq_bridge #(
      .REF_MAX_LENGTH (REF_MAX),
      .READ_MAX_LENGTH(READ_MAX),
      .RES_W          (RES_W),
      .TIMEOUT_CYCLES (TIMEOUT),
      .LEN_W          (LEN_W)
   ) dut (
      .avm_clk        (avm_clk),
      .avm_rst        (avm_rst),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_readdata   (avm_readdata),
      .avm_write      (avm_write),
      .avm_writedata  (avm_writedata),
      .avm_waitrequest(avm_waitrequest),
      .core_in_valid  (core_in_valid),
      .core_in_ready  (core_in_ready),
      .core_ref       (core_ref),
      .core_read      (core_read),
      .core_ref_len   (core_ref_len),
      .core_read_len  (core_read_len),
      .core_out_valid (core_out_valid),
      .core_out_ready (core_out_ready),
      .core_score     (core_score),
      .core_row       (core_row),
      .core_column    (core_column),
      .busy           (busy)
   );

   always #5 avm_clk = ~avm_clk;

   // RX bytes written by the main sequence, consumed by the slave model; TX bytes logged.
   byte unsigned rx_mem [0:4095];
   byte unsigned tx_mem [0:4095];
   int rx_wr = 0;
   int rx_rd = 0;
   int tx_wr = 0;
   int wait_fixed = -1;
   int wcnt = 0;
   int wtarget = 0;
   bit have_prev = 1'b0;
   logic [38:0] prev_req = '0;
   int slv_err = 0;

   int in_delay = 0;
   int icnt = 0;
   int ocnt = 0;
   bit pend = 1'b0;
   int hs_count = 0;
   int core_err = 0;
   logic [REF_W-1:0]  cap_ref = '0;
   logic [READ_W-1:0] cap_read = '0;
   logic [LEN_W-1:0]  cap_rlen = '0;
   logic [LEN_W-1:0]  cap_qlen = '0;

   int n_assert = 0;
   int n_fail = 0;

   // RS232 register slave; decisions are made mid-cycle so the DUT sees them at the next edge.
   always @(negedge avm_clk) begin
      #1;
      if (avm_rst) begin
         avm_waitrequest = 1'b1;
         wcnt = 0;
         have_prev = 1'b0;
      end else begin
         if (avm_read == avm_write) slv_err++;
         if (have_prev && ({avm_read, avm_write, avm_address, avm_writedata} !== prev_req))
            slv_err++;
         if (wcnt < wtarget) begin
            avm_waitrequest = 1'b1;
            wcnt++;
            have_prev = 1'b1;
            prev_req = {avm_read, avm_write, avm_address, avm_writedata};
         end else begin
            avm_waitrequest = 1'b0;
            wcnt = 0;
            have_prev = 1'b0;
            wtarget = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 2));
            avm_readdata = 32'h0;
            if (avm_read && avm_address == 5'd8) begin
               avm_readdata[7] = (rx_wr > rx_rd) && ($urandom_range(0, 3) != 0);
               avm_readdata[6] = ($urandom_range(0, 3) != 0);
            end else if (avm_read && avm_address == 5'd0) begin
               if (rx_wr > rx_rd) begin
                  avm_readdata = {24'($urandom), rx_mem[rx_rd % 4096]};
                  rx_rd++;
               end else begin
                  slv_err++;
               end
            end else if (avm_write && avm_address == 5'd4) begin
               if (avm_writedata[31:8] != 24'h0) slv_err++;
               tx_mem[tx_wr % 4096] = avm_writedata[7:0];
               tx_wr++;
            end else begin
               slv_err++;
            end
         end
      end
   end

   // SW core model: delayed input ready, result returned a couple of cycles later.
   always @(negedge avm_clk) begin
      #1;
      if (avm_rst) begin
         core_in_ready = 1'b0;
         core_out_valid = 1'b0;
         pend = 1'b0;
         icnt = 0;
      end else begin
         if (core_in_ready) begin
            core_in_ready = 1'b0;
         end else if (core_in_valid) begin
            if (icnt >= in_delay) begin
               core_in_ready = 1'b1;
               icnt = 0;
               hs_count++;
               cap_ref = core_ref;
               cap_read = core_read;
               cap_rlen = core_ref_len;
               cap_qlen = core_read_len;
               pend = 1'b1;
               ocnt = 0;
            end else begin
               icnt++;
            end
         end else if (icnt > 0) begin
            core_err++;
            icnt = 0;
         end
         if (core_out_valid) begin
            core_out_valid = 1'b0;
         end else if (pend && core_out_ready) begin
            if (ocnt >= 2) begin
               core_out_valid = 1'b1;
               pend = 1'b0;
            end else begin
               ocnt++;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge avm_clk);
   endtask

   task automatic push_rx(input byte unsigned b);
      rx_mem[rx_wr % 4096] = b;
      rx_wr++;
   endtask

   task automatic run_frame(input string tag, input int rl, input int ql, input int pat,
                            input logic [RES_W-1:0] sc, input logic [RES_W-1:0] rw,
                            input logic [RES_W-1:0] cl);
      logic [REF_W-1:0]  exp_ref;
      logic [READ_W-1:0] exp_read;
      byte unsigned      exp_tx[$];
      byte unsigned      b;
      byte unsigned      x;
      bit                ok;
      int                nref, nread, hs0, tx0, cyc;
      ok = (rl >= 1) && (rl <= int'(REF_MAX)) && (ql >= 1) && (ql <= int'(READ_MAX));
      nref  = ok ? (rl + 3) / 4 : 0;
      nread = ok ? (ql + 3) / 4 : 0;
      exp_ref  = '0;
      exp_read = '0;
      res_score = sc;
      res_row   = rw;
      res_col   = cl;
      hs0 = hs_count;
      tx0 = tx_wr;
      push_rx(8'(rl));
      push_rx(8'(ql));
      for (int k = 0; k < nref; k++) begin
         b = (pat >= 0) ? 8'(pat + k) : 8'($urandom);
         exp_ref |= REF_W'(b) << (REF_W - 8 - 8 * k);
         push_rx(b);
      end
      for (int k = 0; k < nread; k++) begin
         b = (pat >= 0) ? 8'(pat + nref + k) : 8'($urandom);
         exp_read |= READ_W'(b) << (READ_W - 8 - 8 * k);
         push_rx(b);
      end
      if (ok) begin
         for (int i = RES_W / 8 - 1; i >= 0; i--) exp_tx.push_back(8'(cl >> (8 * i)));
         for (int i = RES_W / 8 - 1; i >= 0; i--) exp_tx.push_back(8'(rw >> (8 * i)));
         for (int i = RES_W / 8 - 1; i >= 0; i--) exp_tx.push_back(8'(sc >> (8 * i)));
      end else begin
         exp_tx.push_back(8'hEE);
      end
      if (CHK_EN) begin
         x = 8'h00;
         foreach (exp_tx[i]) x ^= exp_tx[i];
         exp_tx.push_back(x);
      end
      cyc = 0;
      while (!(rx_rd == rx_wr && (tx_wr - tx0) >= exp_tx.size() && busy == 1'b0) &&
             cyc < LIMIT) begin
         @(negedge avm_clk);
         cyc++;
      end
      chk({tag, " completes"}, cyc < LIMIT, 1'b1);
      idle(4);
      chk({tag, " tx_count"}, tx_wr - tx0, exp_tx.size());
      foreach (exp_tx[i])
         chk($sformatf("%s tx[%0d]", tag, i),
             (tx0 + i < tx_wr) ? 9'(tx_mem[(tx0 + i) % 4096]) : 9'h1FF, exp_tx[i]);
      chk({tag, " core_handshakes"}, hs_count - hs0, ok ? 1 : 0);
      chk({tag, " busy_end"}, busy, 1'b0);
      if (ok) begin
         chk({tag, " core_ref"}, cap_ref, exp_ref);
         chk({tag, " core_read"}, cap_read, exp_read);
         chk({tag, " ref_len"}, cap_rlen, rl);
         chk({tag, " read_len"}, cap_qlen, ql);
      end
   endtask

   initial begin
      int cyc;
      int hs0;
      int tx0;
      // Reset state
      idle(3);
      chk("rst avm_read", avm_read, 1'b1);
      chk("rst avm_address", avm_address, 5'd8);
      chk("rst avm_write", avm_write, 1'b0);
      chk("rst avm_writedata", avm_writedata, 32'h0);
      chk("rst core_in_valid", core_in_valid, 1'b0);
      chk("rst core_out_ready", core_out_ready, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst core_ref", core_ref, '0);
      chk("rst core_read", core_read, '0);
      chk("rst ref_len", core_ref_len, '0);
      chk("rst read_len", core_read_len, '0);
      avm_rst = 1'b0;
      idle(2);

      run_frame("full", 128, 128, 8'h1B, 64'd5, 64'd7, 64'd9);
      run_frame("short", 5, 3, 8'hC4, 64'h1122_3344_5566_7788, 64'hA, 64'hFFFF_0000_1234_5678);

      // Header errors, then a good frame
      run_frame("hdr_zero", 0, 4, -1, 64'd1, 64'd2, 64'd3);
      run_frame("hdr_over", 8'h81, 8, -1, 64'd1, 64'd2, 64'd3);
      run_frame("hdr_read0", 10, 0, -1, 64'd1, 64'd2, 64'd3);
      run_frame("hdr_read_over", 16, int'($urandom_range(129, 255)), -1, 64'd1, 64'd2, 64'd3);
      run_frame("after_err", 20, 17, -1, 64'd42, 64'd43, 64'd44);

      // Partial frame abandoned by the inactivity timeout
      hs0 = hs_count;
      tx0 = tx_wr;
      push_rx(8'h40);
      push_rx(8'h40);
      for (int k = 0; k < 10; k++) push_rx(8'($urandom));
      cyc = 0;
      while (rx_rd != rx_wr && cyc < LIMIT) begin
         @(negedge avm_clk);
         cyc++;
      end
      chk("to partial_consumed", cyc < LIMIT, 1'b1);
      idle(2);
      chk("to busy_mid", busy, 1'b1);
      idle(TIMEOUT - 50);
      chk("to busy_before_limit", busy, 1'b1);
      idle(100);
      chk("to busy_after_limit", busy, 1'b0);
      chk("to no_tx", tx_wr - tx0, 0);
      chk("to no_core", hs_count - hs0, 0);
      run_frame("after_to", 12, 9, -1, 64'd100, 64'd200, 64'd300);

      // Synchronous reset in the middle of a frame
      push_rx(8'h20);
      push_rx(8'h20);
      for (int k = 0; k < 3; k++) push_rx(8'($urandom));
      cyc = 0;
      while (rx_rd != rx_wr && cyc < LIMIT) begin
         @(negedge avm_clk);
         cyc++;
      end
      idle(2);
      chk("mid_rst busy_before", busy, 1'b1);
      avm_rst = 1'b1;
      @(negedge avm_clk);
      chk("mid_rst busy", busy, 1'b0);
      chk("mid_rst ref_len", core_ref_len, '0);
      chk("mid_rst core_ref", core_ref, '0);
      chk("mid_rst avm_read", avm_read, 1'b1);
      chk("mid_rst avm_address", avm_address, 5'd8);
      avm_rst = 1'b0;
      idle(2);
      run_frame("after_rst", 7, 128, -1, 64'd11, 64'd12, 64'd13);

      // Stalled bus and slow core
      wait_fixed = 3;
      in_delay = 4;
      run_frame("stall", 128, 128, 8'h1B, 64'd5, 64'd7, 64'd9);
      wait_fixed = -1;
      in_delay = 0;

      run_frame("score1", 8, 8, -1, 64'd1, 64'd0, 64'd0);

      for (int f = 0; f < 4; f++) begin
         in_delay = int'($urandom_range(0, 5));
         run_frame($sformatf("rnd%0d", f), int'($urandom_range(1, REF_MAX)),
                   int'($urandom_range(1, READ_MAX)), -1, RES_W'({$urandom, $urandom}),
                   RES_W'({$urandom, $urandom}), RES_W'({$urandom, $urandom}));
      end

      chk("avalon_protocol_errors", slv_err, 0);
      chk("core_handshake_errors", core_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
